// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Memory-mapped UART transmit sequencer. Catches MEM-stage stores
//             to the UART TX register block, queues bytes in a small circular
//             FIFO and hands them one at a time to the UART TX core with a
//             start/done handshake. Owns the sticky TX-complete, overflow and
//             timeout flags that software polls and clears.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   single clock
//    reset        in   synchronous, active-high
//    address      in   MEM-stage byte address
//    write_data   in   store data (low DATA_WIDTH bits are the pushed byte)
//    swdetect     in   store strobe for the current cycle
//    read_data    out  status word, combinational from address
//    tx_data      out  byte presented to the UART core (registered)
//    tx_start     out  one-cycle launch pulse to the UART core
//    tx_busy      in   UART core is shifting
//    tx_done      in   one-cycle completion pulse from the UART core
//    tx_flag      out  sticky: an armed burst finished
//    overflow     out  sticky: a push was dropped on a full FIFO
//    timeout      out  sticky: tx_done not seen within TIMEOUT_CYCLES
//    fifo_empty   out  FIFO holds no bytes
//    fifo_full    out  FIFO holds FIFO_DEPTH bytes
//  Register map (effective only while swdetect = 1)
//    0x1001002C  push byte           (read: status word)
//    0x1001002D  clear sticky flags
//    0x1001002E  kick (arm the transmitter)
// ============================================================================
module uart_tx_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  input  logic                  swdetect,
  output logic [31:0]           read_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic                  tx_flag,
  output logic                  overflow,
  output logic                  timeout,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_PUSH  = ADDR_WIDTH'(32'h1001_002C);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_CLEAR = ADDR_WIDTH'(32'h1001_002D);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_KICK  = ADDR_WIDTH'(32'h1001_002E);

  localparam logic [CNT_W-1:0] C_COUNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] C_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_armed;
  logic                  r_tx_flag;
  logic                  r_overflow;
  logic                  r_timeout;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_start;
  logic [TMO_W-1:0]      r_tmo_cnt;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  w_push_req;
  logic                  w_clear_req;
  logic                  w_kick_req;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_push_drop;
  logic                  w_kick_ok;
  logic                  w_last_done;
  logic [TMO_W-1:0]      w_tmo_inc;
  logic                  w_tmo_hit;
  logic [1:0]            w_state_next;

  assign w_push_req  = swdetect && (address == C_ADDR_PUSH);
  assign w_clear_req = swdetect && (address == C_ADDR_CLEAR);
  assign w_kick_req  = swdetect && (address == C_ADDR_KICK);

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == C_COUNT_FULL);

  // Pop only happens on the IDLE->LAUNCH transition.
  assign w_pop = (r_state == S_IDLE) && r_armed && !w_fifo_empty && !tx_busy;

  // A pop in the same cycle frees a slot, so a push on a full FIFO survives.
  assign w_push_ok   = w_push_req && (!w_fifo_full || w_pop);
  assign w_push_drop = w_push_req && w_fifo_full && !w_pop;

  // Arming an empty FIFO is meaningless unless a byte lands the same cycle.
  assign w_kick_ok = w_kick_req && (!w_fifo_empty || w_push_req);

  // Burst ends when the last byte completes and nothing new was pushed.
  assign w_last_done = (r_state == S_WAIT_DONE) && tx_done
                       && w_fifo_empty && !w_push_req;

  // The counter is 0 in the first WAIT_DONE cycle; firing when the incremented
  // value reaches TIMEOUT_CYCLES-1 puts the flag exactly TIMEOUT_CYCLES cycles
  // after the LAUNCH cycle.
  assign w_tmo_inc = (r_tmo_cnt == C_TMO_LAST) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
  assign w_tmo_hit = (r_state == S_WAIT_DONE) && !tx_done
                     && (w_tmo_inc == C_TMO_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done || w_tmo_hit) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; validity is tracked by r_count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= write_data[DATA_WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Control, pointers, flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_armed    <= 1'b0;
      r_tx_flag  <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr];
      end

      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end

      // Registered pulse lines up with the single LAUNCH cycle.
      r_tx_start <= w_pop;

      // Disarming events take precedence over a coincident kick.
      if (w_last_done || w_tmo_hit) begin
        r_armed <= 1'b0;
      end else if (w_kick_ok) begin
        r_armed <= 1'b1;
      end

      // Sticky flags: a set event beats a same-cycle clear.
      if (w_last_done) begin
        r_tx_flag <= 1'b1;
      end else if (w_clear_req) begin
        r_tx_flag <= 1'b0;
      end

      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end else if (w_clear_req) begin
        r_overflow <= 1'b0;
      end

      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end else if (w_clear_req) begin
        r_timeout <= 1'b0;
      end

      if (r_state == S_LAUNCH) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_tmo_cnt <= w_tmo_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status read-back
  // --------------------------------------------------------------------------
  always_comb begin
    read_data = '0;
    if (address == C_ADDR_PUSH) begin
      read_data[8 +: CNT_W] = r_count;
      read_data[4]          = r_timeout;
      read_data[3]          = r_armed;
      read_data[2]          = r_overflow;
      read_data[1]          = r_tx_flag;
      read_data[0]          = w_fifo_empty;
    end
  end

  // Upper store-data bits are not part of any register.
  generate
    if (DATA_WIDTH < 32) begin : g_unused_wdata
      logic w_unused_wdata;
      assign w_unused_wdata = ^write_data[31:DATA_WIDTH];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign tx_flag    = r_tx_flag;
  assign overflow   = r_overflow;
  assign timeout    = r_timeout;
  assign fifo_empty = w_fifo_empty;
  assign fifo_full  = w_fifo_full;

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequences the memory-mapped UART transmitter. It accepts MIPS store traffic at the UART TX register addresses, buffers bytes in a small FIFO, and launches them one at a time into the UART TX core using a start/done handshake. It sits between the MEM-stage bus and the UART TX core, alongside the address-translation/peripheral-select logic. It owns the sticky TX-complete, overflow and timeout flags that software polls and clears.

## Interface
- `DATA_WIDTH`, default 8: UART byte width.
- `FIFO_DEPTH`, default 4: number of buffered bytes; must be a power of 2, at least 2.
- `ADDR_WIDTH`, default 32: bus address width.
- `TIMEOUT_CYCLES`, default 4096: maximum number of cycles to wait for `tx_done` after a launch.
- `clk` in, 1: the single clock.
- `reset` in, 1: synchronous, active-high.
- `address` in, ADDR_WIDTH: MEM-stage byte address.
- `write_data` in, 32: store data.
- `swdetect` in, 1: store strobe for the current cycle.
- `read_data` out, 32: status word, combinational from `address`.
- `tx_data` out, DATA_WIDTH: byte presented to the UART core.
- `tx_start` out, 1: one-cycle launch pulse to the UART core.
- `tx_busy` in, 1: UART core is shifting.
- `tx_done` in, 1: one-cycle pulse from the UART core when a byte completes.
- `tx_flag` out, 1: sticky; set when an armed burst finishes.
- `overflow` out, 1: sticky; a push was dropped because the FIFO was full.
- `timeout` out, 1: sticky; `tx_done` was not seen within TIMEOUT_CYCLES.
- `fifo_empty` out, 1: FIFO holds no bytes.
- `fifo_full` out, 1: FIFO holds FIFO_DEPTH bytes.

## Operation
- **Register map.** All register actions take effect only when `swdetect`=1.
  - 0x1001002C: push; the byte pushed is `write_data[DATA_WIDTH-1:0]`.
  - 0x1001002D: clear `tx_flag`, `overflow` and `timeout`.
  - 0x1001002E: kick; sets `armed`.
- **Status read.**
  - When `address` = 0x1001002C: `read_data` = {zeros, `count`[bits 8+:log2(FIFO_DEPTH)+1], `timeout`[4], `armed`[3], `overflow`[2], `tx_flag`[1], `fifo_empty`[0]}.
  - For any other address: `read_data` = 0.
- **FIFO.**
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - `count` ranges 0..FIFO_DEPTH.
  - If a push arrives while full and no pop happens that cycle, the push is dropped and `overflow` is set.
  - A push and a pop in the same cycle are both performed. When the FIFO is full, that push is accepted.
- **Kick with an empty FIFO.** If the kick arrives while the FIFO is empty and no push happens in the same cycle, the kick is ignored and `armed` stays 0.
- **FSM states:** IDLE, LAUNCH, WAIT_DONE.
  - IDLE -> LAUNCH when `armed` & !`fifo_empty` & !`tx_busy`. On this transition the head byte is popped into the `tx_data` register.
  - LAUNCH -> WAIT_DONE unconditionally. `tx_start`=1 only while in LAUNCH.
  - WAIT_DONE -> IDLE on `tx_done`. If the FIFO is empty at that point (counting a same-cycle push as non-empty), `armed` is cleared and `tx_flag` is set.
  - WAIT_DONE -> IDLE when the timeout counter reaches TIMEOUT_CYCLES-1 without `tx_done`. `timeout` is set, `armed` is cleared, and the FIFO contents are kept.
- **Timeout counter.** It resets on entry to WAIT_DONE and saturates; it does not wrap.
- **Ignored inputs.** `tx_done` is ignored in IDLE and in LAUNCH.
- **Flag priority.** If a clear write coincides with a set event, the set wins.
- **Reset.**
  - State is IDLE, the pointers and `count` are 0, and `armed` is 0.
  - All flags are 0.
  - `tx_data` = 0 and `tx_start` = 0.
  - `fifo_empty` = 1 and `fifo_full` = 0.
  - A UART byte already in flight is not aborted; its `tx_done` lands while the FSM is in IDLE and is ignored.

## Timing
- All outputs are registered except `read_data`, `fifo_empty` and `fifo_full`, which decode from registered state.
- **Launch latency.** A push in cycle N to an armed, idle block with `tx_busy`=0 produces:
  - cycle N+1: FIFO non-empty; the FSM takes IDLE->LAUNCH.
  - cycle N+2: `tx_start`=1 and `tx_data` is valid.
- `tx_data` holds its value until the next LAUNCH.
- **Back-to-back bytes.** A `tx_done` in cycle M gives IDLE at M+1 and the next `tx_start` at M+2, provided `tx_busy`=0 at M+1.
- `tx_flag` becomes visible in the cycle after the final `tx_done`.
- **Clears.** A clear write in cycle N drops the flags at N+1.
- **Timeout.** `timeout` asserts TIMEOUT_CYCLES cycles after LAUNCH.

## Test plan
- **Reset and single byte.** After reset, push 0x41, then kick.
  - Required: `tx_start` is a single-cycle pulse with `tx_data`=0x41, 2 cycles after the kick.
  - After the bench returns `tx_done`: `tx_flag`=1, `armed`=0, `fifo_empty`=1.
- **Burst of four.** Push 0x10..0x13 (FIFO_DEPTH=4), kick, and respond to each launch with `tx_done` after 10 cycles.
  - Required: four launches in order 0x10, 0x11, 0x12, 0x13, each `tx_start` exactly 2 cycles after the previous `tx_done`.
  - `tx_flag` is set only after the fourth byte.
- **Overflow.** Push 5 bytes without a kick.
  - Required: `fifo_full`=1 and `overflow`=1; `count` reads 4 at bits [10:8].
  - After a kick, the bytes sent are the first 4; the fifth is lost.
- **Full with simultaneous push and pop.** With the FIFO full and armed, push 0x77 in the IDLE->LAUNCH pop cycle.
  - Required: no overflow, `count` stays 4, and 0x77 is sent last.
- **Timeout.** Kick with one byte and never assert `tx_done`.
  - Required: `timeout`=1 after TIMEOUT_CYCLES cycles, `armed`=0, state IDLE.
  - A write to 0x1001002D clears `timeout` in the next cycle.
- **Reset mid-burst and clear/set collision.**
  - Assert `reset` during WAIT_DONE. Required: all outputs return to their reset values on the next edge, and a late `tx_done` causes no launch.
  - Issue a clear in the same cycle as the final `tx_done`. Required: `tx_flag`=1.
